// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of a synchronous FIFO among NUM_REQ producers.
// Ownership rotates round-robin. An owner keeps the port for at most MAX_BURST
// consecutive writes, or until it drops req_valid. The FIFO full flag only
// stalls the owner; it never causes a release. Because no write is issued
// while full is high, the FIFO cannot overflow.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset; also blanks req_ready, w_en
//              and data_in in the reset cycle
//   req_valid  per-requester "word available"
//   req_data   flat bus, requester i at [i*WIDTH +: WIDTH]
//   req_ready  per-requester "word accepted this cycle"
//   full       FIFO full flag
//   w_en       FIFO write enable
//   data_in    FIFO write data (owner's word while owning, else 0)
//   gnt_id     current owner index (registered)
//   busy       1 while a requester owns the port (registered)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       full,
    output logic                       w_en,
    output logic [WIDTH-1:0]           data_in,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]   NUM_REQ_W  = (IDW + 1)'(NUM_REQ);
    localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST);

    logic [0:0]     fsm_q,       fsm_d;
    logic [IDW-1:0] owner_q,     owner_d;
    logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
    logic [7:0]     burst_cnt_q, burst_cnt_d;

    logic [WIDTH-1:0] req_words_s [NUM_REQ];
    logic             own_s;
    logic             owner_valid_s;
    logic [IDW-1:0]   owner_next_s;
    logic [IDW:0]     pick_rr_s;
    logic [IDW:0]     pick_next_s;
    logic             release_s;

    // Round-robin search: first valid index at or after start, wrapping
    // modulo NUM_REQ (valid for non-power-of-2 counts). Result is {found, idx}.
    function automatic logic [IDW:0] pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IDW-1:0]     start);
        logic           found;
        logic           hit;
        logic [IDW-1:0] idx;
        logic [IDW:0]   sum;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum   = {1'b0, start} + (IDW + 1)'(k);
            sum   = (sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum;
            hit   = !found && valid[sum[IDW-1:0]];
            idx   = hit ? sum[IDW-1:0] : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

    // Unpack the flat request bus and derive owner-related helpers.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_words_s[i] = req_data[i*WIDTH +: WIDTH];
        end
        own_s         = (fsm_q == ST_OWN);
        owner_valid_s = req_valid[owner_q];
        owner_next_s  = (owner_q == LAST_ID) ? {IDW{1'b0}} : (owner_q + {{(IDW-1){1'b0}}, 1'b1});
        pick_rr_s     = pick(req_valid, rr_ptr_q);
        pick_next_s   = pick(req_valid, owner_next_s);
    end

    // FIFO-side and requester-side handshake outputs; all blanked during reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && own_s && !full && (owner_q == IDW'(i));
        end
        w_en = !rst && own_s && owner_valid_s && !full;
        if (!rst && own_s) begin
            data_in = req_words_s[owner_q];
        end else begin
            data_in = {WIDTH{1'b0}};
        end
    end

    // Next-state logic: grant from IDLE, stall/write/release while owning.
    always_comb begin
        fsm_d       = fsm_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        release_s   = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (pick_rr_s[IDW]) begin
                    fsm_d       = ST_OWN;
                    owner_d     = pick_rr_s[IDW-1:0];
                    burst_cnt_d = 8'd0;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_valid_s) begin
                    release_s = 1'b1;
                end else if (full) begin
                    // Stall: everything holds, full never ends a grant.
                    burst_cnt_d = burst_cnt_q;
                end else if ((burst_cnt_q + 8'd1) == BURST_LAST) begin
                    release_s = 1'b1;
                end else begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                if (release_s) begin
                    rr_ptr_d    = owner_next_s;
                    burst_cnt_d = 8'd0;
                    // Zero-bubble handoff when anyone (possibly the releasing
                    // requester itself) is still waiting.
                    if (pick_next_s[IDW]) begin
                        owner_d = pick_next_s[IDW-1:0];
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            owner_q     <= {IDW{1'b0}};
            rr_ptr_q    <= {IDW{1'b0}};
            burst_cnt_q <= 8'd0;
        end else begin
            fsm_q       <= fsm_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign gnt_id = owner_q;
    assign busy   = (fsm_q == ST_OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for fifo_wr_arbiter. A 4-requester instance is driven by directed and
// random traffic. A behavioural model predicts the control outputs each cycle,
// and a queue of expected FIFO words is drained by an independent monitor on
// every w_en. A 3-requester instance covers wrap-around of the rotation.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int MAXB   = 4;
    localparam int FDEPTH = 8;

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           full;
    logic           w_en;
    logic [W-1:0]   data_in;
    logic [1:0]     gnt_id;
    logic           busy;

    logic           rst3;
    logic [2:0]     req_valid3;
    logic [23:0]    req_data3;
    logic [2:0]     req_ready3;
    logic           full3;
    logic           w_en3;
    logic [7:0]     data_in3;
    logic [1:0]     gnt_id3;
    logic           busy3;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MAXB)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .full(full), .w_en(w_en), .data_in(data_in),
        .gnt_id(gnt_id), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(8), .MAX_BURST(2)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .full(full3), .w_en(w_en3), .data_in(data_in3),
        .gnt_id(gnt_id3), .busy(busy3)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int           writes_seen = 0;

    // behavioural model state
    bit m_own;
    int m_owner, m_rr, m_cnt;
    int rem[N];
    int seq[N];
    int occ;

    function automatic int first_valid(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // word tag: requester id in the top bits, running sequence number below
    function automatic logic [W-1:0] word_of(input int i, input int s);
        return {i[1:0], s[5:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit any_rem();
        for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: entered at posedge+1, drives inputs, checks, advances model.
    task automatic step(input logic [N-1:0] vmask, input logic f, input logic r);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic         exp_w;
        logic [W-1:0] exp_d;
        int           nxt;
        bit           rel;
        for (int i = 0; i < N; i++) begin
            v[i] = vmask[i] && (rem[i] > 0);
            req_data[i*W +: W] = word_of(i, seq[i]);
        end
        req_valid = v;
        full      = f;
        rst       = r;
        #3;
        exp_rdy = '0;
        exp_w   = 1'b0;
        exp_d   = '0;
        if (!r && m_own) begin
            exp_rdy[m_owner] = !f;
            exp_w            = v[m_owner] && !f;
            exp_d            = word_of(m_owner, seq[m_owner]);
        end
        check("busy", busy, m_own);
        check("gnt_id", gnt_id, m_owner);
        check("w_en", w_en, exp_w);
        check("req_ready", req_ready, exp_rdy);
        check("data_in", data_in, exp_d);
        if (exp_w) exp_q.push_back(exp_d);
        if (r) begin
            m_own = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
        end else if (!m_own) begin
            nxt = first_valid(v, m_rr);
            if (nxt >= 0) begin m_own = 1; m_owner = nxt; m_cnt = 0; end
        end else begin
            rel = 0;
            if (!v[m_owner]) rel = 1;
            else if (!f) begin
                seq[m_owner]++; rem[m_owner]--; occ++; m_cnt++;
                if (m_cnt == MAXB) rel = 1;
            end
            if (rel) begin
                m_rr = (m_owner + 1) % N;
                nxt  = first_valid(v, m_rr);
                m_cnt = 0;
                if (nxt >= 0) m_owner = nxt;
                else m_own = 0;
            end
        end
        if (occ > 0 && $urandom_range(0, 2) == 0) occ--;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        for (int i = 0; i < N; i++) rem[i] = 0;
        step('0, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: every FIFO write must match the oldest prediction.
    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            writes_seen++;
            n_cmp++;
            if (full !== 1'b0) begin
                n_err++;
                $display("FAIL no_overflow: w_en with full=%b", full);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fifo_word: got %0h expected none", data_in);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_in !== mon_exp) begin
                    n_err++;
                    $display("FAIL fifo_word: got %0h expected %0h", data_in, mon_exp);
                end
            end
        end
    end

    initial begin
        int cycles;
        int w0;
        int g;
        rst = 1'b1; req_valid = '0; req_data = '0; full = 1'b0;
        rst3 = 1'b1; req_valid3 = 3'b000; req_data3 = {8'hA2, 8'hA1, 8'hA0}; full3 = 1'b0;
        m_own = 0; m_owner = 0; m_rr = 0; m_cnt = 0; occ = 0;
        for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
        @(posedge clk); #1;
        reset_all();
        reset_all();

        // single requester, 6 words: grant, 4 writes, handoff to itself, 2 writes
        rem[0] = 6; cycles = 0; w0 = writes_seen;
        while (rem[0] > 0 && cycles < 30) begin step(4'b0001, 1'b0, 1'b0); cycles++; end
        check("t1_cycles", cycles, 7);
        check("t1_writes", writes_seen - w0, 6);

        // all requesters valid: one grant cycle then a write every cycle
        reset_all();
        for (int i = 0; i < N; i++) rem[i] = 12;
        cycles = 0; w0 = writes_seen;
        while (any_rem() && cycles < 200) begin step(4'b1111, 1'b0, 1'b0); cycles++; end
        check("t2_cycles", cycles, 49);
        check("t2_writes", writes_seen - w0, 48);

        // owner 1 stalled by full for 3 cycles mid-burst
        reset_all();
        rem[1] = 6; w0 = writes_seen;
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 1'b1, 1'b0);
            check("t3_stall_gnt", gnt_id, 1);
        end
        cycles = 0;
        while (rem[1] > 0 && cycles < 20) begin step(4'b0010, 1'b0, 1'b0); cycles++; end
        check("t3_writes", writes_seen - w0, 6);

        // owner 2 drops valid after 2 words, requester 3 takes over
        reset_all();
        rem[2] = 5; rem[3] = 3;
        step(4'b0100, 1'b0, 1'b0);
        step(4'b1100, 1'b0, 1'b0);
        step(4'b1100, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        check("t4_gnt", gnt_id, 3);
        step(4'b1000, 1'b0, 1'b0);

        // reset in the middle of a burst
        reset_all();
        rem[1] = 8; rem[2] = 8;
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b1);
        check("t5_busy_after_rst", busy, 0);
        check("t5_gnt_after_rst", gnt_id, 0);
        step(4'b0110, 1'b0, 1'b0);
        check("t5_regrant", gnt_id, 1);

        // random traffic against a depth-8 FIFO occupancy model
        reset_all();
        occ = 0;
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] vm;
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 10);
                vm[i] = ($urandom_range(0, 9) != 0);
            end
            step(vm, (occ >= FDEPTH), 1'b0);
        end
        reset_all();

        // three requesters, 0 and 2 valid, burst 2: 0,0,2,2,0,0,2,2
        rst = 1'b1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        req_valid3 = 3'b101;
        #3;
        check("t6_idle_busy", busy3, 0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #4;
            g = (((c / 2) % 2) == 0) ? 0 : 2;
            check("t6_gnt", gnt_id3, g);
            check("t6_w_en", w_en3, 1);
            check("t6_data", data_in3, 8'hA0 + g);
        end
        @(posedge clk); #1;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
